// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer-side request bus plus fifo write port of the shared fifo.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_full;
  logic                   fifo_wr_en;
  logic [WIDTH-1:0]       fifo_din;
  logic [IW-1:0]          grant_id;
  logic                   busy;
  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );
  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked sharing of one fifo write port among N_REQ producers.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  arb_if
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d, rr_ptr_q, rr_ptr_d, winner, idx;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              found, beat, release_now;
  logic [WIDTH-1:0]  data_a [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_data
    assign data_a[g] = arb_if.req_data[g*WIDTH +: WIDTH];
  end
  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && arb_if.req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
  assign beat        = state_q == LOCKED && arb_if.req_valid[owner_q] && !arb_if.fifo_full;
  assign release_now = beat && (arb_if.req_last[owner_q] || beat_cnt_q == CW'(MAX_BURST - 1));
  assign arb_if.req_ready  = (state_q == LOCKED && !arb_if.fifo_full) ? N_REQ'(1) << owner_q : '0;
  assign arb_if.fifo_wr_en = beat;
  assign arb_if.fifo_din   = data_a[owner_q];
  assign arb_if.grant_id   = owner_q;
  assign arb_if.busy       = state_q == LOCKED;
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d    = LOCKED;
        owner_d    = winner;
        beat_cnt_d = '0;
      end
    end else if (release_now) begin
      state_d    = IDLE;
      rr_ptr_d   = owner_q == IW'(N_REQ - 1) ? '0 : owner_q + 1'b1;
      beat_cnt_d = '0;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios with fixed expectations plus random traffic against a grant-level model.
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, MB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0;
  logic       m_locked = 1'b0;
  logic [1:0] m_owner = '0, m_ptr = '0;
  int         m_beats = 0;
  logic [7:0] st;
  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();
  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .arb_if(bus));
  always #5 clk = ~clk;
  assign st = {bus.req_ready, bus.fifo_wr_en, bus.busy, bus.grant_id};
  // reference: who holds the port, where the next search starts, beats in this grant
  always @(posedge clk or posedge rst) begin : model
    int w;
    logic [1:0] c;
    w = -1;
    for (int k = N - 1; k >= 0; k--) begin
      c = m_ptr + 2'(k);
      if (bus.req_valid[c]) w = int'(c);
    end
    if (rst) begin
      m_locked <= 1'b0; m_owner <= '0; m_ptr <= '0; m_beats <= 0;
    end else if (!m_locked) begin
      if (w >= 0) begin m_owner <= 2'(w); m_locked <= 1'b1; m_beats <= 0; end
    end else if (bus.req_valid[m_owner] && !bus.fifo_full) begin
      if (bus.req_last[m_owner] || m_beats + 1 == MB) begin
        m_locked <= 1'b0; m_ptr <= m_owner + 1'b1; m_beats <= 0;
      end else m_beats <= m_beats + 1;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      bus.req_valid = 4'($urandom); bus.req_last = 4'($urandom);
      bus.req_data = $urandom; bus.fifo_full = 1'($urandom);
      @(negedge clk);
      total++;
      if (st !== 8'h00) begin bad++; $display("FAIL reset k=%0d got=%h exp=00", k, st); end
    end
    cyc();
    rst = 1'b0; bus.req_valid = '0; bus.req_last = '0; bus.fifo_full = 1'b0;
  endtask
  task automatic test_single_burst();
    logic [3:0]  tv [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1010, 4'b1000, 4'b0000};
    logic [3:0]  tl [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1010, 4'b1000, 4'b0000};
    logic [31:0] td [8] = '{32'h00A10000, 32'h00A10000, 32'h00A20000, 32'h00A30000, 32'h0, 32'hB300B100, 32'hB300B100, 32'h0};
    logic [7:0]  ts [8] = '{8'h00, 8'h4E, 8'h4E, 8'h4E, 8'h02, 8'h02, 8'h8F, 8'h03};
    logic [7:0]  tw [8] = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'hB3, 8'h00};
    for (int k = 0; k < 8; k++) begin
      cyc();
      bus.req_valid = tv[k]; bus.req_last = tl[k]; bus.req_data = td[k];
      @(negedge clk);
      total++;
      if (st !== ts[k]) begin bad++; $display("FAIL burst2_st k=%0d got=%h exp=%h", k, st, ts[k]); end
      if (ts[k][3]) begin
        total++;
        if (bus.fifo_din !== tw[k]) begin bad++; $display("FAIL burst2_din k=%0d got=%h exp=%h", k, bus.fifo_din, tw[k]); end
      end
    end
  endtask
  task automatic test_round_robin();
    int g;
    logic [7:0] e;
    for (int k = 0; k <= 10; k++) begin
      cyc();
      bus.req_valid = k < 10 ? 4'hF : 4'h0; bus.req_last = 4'hF; bus.req_data = 32'h13121110;
      @(negedge clk);
      g = k == 0 ? 3 : ((k - 1) / 2) % 4;
      e = (k % 2 == 1) ? {4'(1 << g), 1'b1, 1'b1, 2'(g)} : {6'b0, 2'(g)};
      total++;
      if (st !== e) begin bad++; $display("FAIL rr_st k=%0d got=%h exp=%h", k, st, e); end
      if (k % 2 == 1) begin
        total++;
        if (bus.fifo_din !== 8'(16 + g)) begin bad++; $display("FAIL rr_din k=%0d got=%h exp=%h", k, bus.fifo_din, 8'(16 + g)); end
      end
    end
  endtask
  task automatic test_max_burst();
    int j1 = 0, j3 = 0, e;
    for (int k = 0; k < 18; k++) begin
      cyc();
      bus.req_valid = {j3 < 1, 1'b0, j1 < 12, 1'b0}; bus.req_last = 4'b1000;
      bus.req_data = {8'h77, 8'h00, 8'(32'h50 + j1), 8'h00};
      @(negedge clk);
      e = ((k >= 1 && k <= 4) || (k >= 8 && k <= 11) || (k >= 13 && k <= 16)) ? 1 : (k == 6 ? 3 : -1);
      total++;
      if (e >= 0) begin
        if (st !== {4'(1 << e), 1'b1, 1'b1, 2'(e)}) begin bad++; $display("FAIL maxb_st k=%0d got=%h exp_owner=%0d", k, st, e); end
        total++;
        if (bus.fifo_din !== (e == 1 ? 8'(32'h50 + j1) : 8'h77)) begin bad++; $display("FAIL maxb_din k=%0d got=%h", k, bus.fifo_din); end
      end else if (st[7:2] !== 6'b0) begin bad++; $display("FAIL maxb_idle k=%0d got=%h exp=idle", k, st); end
      if (bus.req_ready[1] && bus.req_valid[1]) j1++;
      if (bus.req_ready[3] && bus.req_valid[3]) j3++;
    end
  endtask
  task automatic test_full_stall();
    int j = 0, wr = 0;
    logic full;
    logic [7:0] e;
    for (int k = 0; k < 8; k++) begin
      cyc();
      full = k == 2 || k == 3;
      bus.fifo_full = full; bus.req_valid = {2'b0, j < 4, 1'b0}; bus.req_last = {2'b0, j == 3, 1'b0};
      bus.req_data = {16'h0, 8'(32'h30 + j), 8'h00};
      @(negedge clk);
      e = (k >= 1 && k <= 6) ? {full ? 4'b0000 : 4'b0010, !full, 1'b1, 2'd1} : 8'h01;
      total++;
      if (st !== e) begin bad++; $display("FAIL full_st k=%0d got=%h exp=%h", k, st, e); end
      if (bus.fifo_wr_en) begin
        wr++;
        total++;
        if (bus.fifo_din !== 8'(32'h30 + j)) begin bad++; $display("FAIL full_din k=%0d got=%h exp=%h", k, bus.fifo_din, 8'(32'h30 + j)); end
      end
      if (bus.req_ready[1] && bus.req_valid[1]) j++;
    end
    bus.fifo_full = 1'b0;
    total++;
    if (wr !== 4) begin bad++; $display("FAIL full_count got=%0d exp=4", wr); end
  endtask
  task automatic test_rst_mid_burst();
    logic [7:0] ts [5] = '{8'h01, 8'h4E, 8'h4E, 8'h00, 8'h00};
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 4) rst = 1'b0;
      bus.req_valid = k < 3 ? 4'b0100 : 4'b1110; bus.req_last = 4'b1110;
      bus.req_data = {8'hD3, 8'(32'hC0 + k), 8'hD1, 8'hD0};
      bus.req_last = k < 3 ? 4'b0000 : 4'b1110;
      @(negedge clk);
      total++;
      if (st !== ts[k]) begin bad++; $display("FAIL rstm_st k=%0d got=%h exp=%h", k, st, ts[k]); end
      if (k == 2) begin
        rst = 1'b1;
        #1;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL rstm_async got=%h exp=00", st); end
      end
    end
    cyc();
    @(negedge clk);
    total++;
    if (st !== 8'h2D) begin bad++; $display("FAIL rstm_regrant got=%h exp=2d", st); end
    cyc();
    bus.req_valid = '0; bus.req_last = '0;
    @(negedge clk);
    total++;
    if (st !== 8'h01) begin bad++; $display("FAIL rstm_release got=%h exp=01", st); end
  endtask
  task automatic test_random();
    logic [3:0] r;
    logic       we;
    logic [7:0] e;
    for (int k = 0; k < 600; k++) begin
      cyc();
      rst = $urandom_range(0, 99) == 0;
      bus.req_valid = 4'($urandom); bus.req_last = 4'($urandom & $urandom);
      bus.req_data = $urandom; bus.fifo_full = $urandom_range(0, 3) == 0;
      @(negedge clk);
      r  = (m_locked && !bus.fifo_full) ? 4'b0001 << m_owner : 4'b0000;
      we = m_locked && bus.req_valid[m_owner] && !bus.fifo_full;
      e  = {r, we, m_locked, m_owner};
      total++;
      if (st !== e) begin bad++; $display("FAIL rand_st k=%0d got=%h exp=%h", k, st, e); end
      if (we) begin
        total++;
        if (bus.fifo_din !== 8'(bus.req_data >> (8 * m_owner))) begin
          bad++; $display("FAIL rand_din k=%0d got=%h exp=%h", k, bus.fifo_din, 8'(bus.req_data >> (8 * m_owner)));
        end
      end
    end
    cyc();
    rst = 1'b0; bus.req_valid = '0; bus.req_last = '0; bus.fifo_full = 1'b0;
  endtask
  initial begin
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_rst_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
